// File: rtl/apb_chk_pkg.sv
// Shared types and helpers for the APB4 protocol checker.
package apb_chk_pkg;

  // Monitor phase for the sample being evaluated.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } chk_state_e;

  // Bit positions inside err_pulse / err_sticky.
  localparam int unsigned ERR_ILLEGAL   = 0;
  localparam int unsigned ERR_UNSTABLE  = 1;
  localparam int unsigned ERR_TIMEOUT   = 2;
  localparam int unsigned ERR_MULTI_SEL = 3;
  localparam int unsigned ERR_STRB_READ = 4;
  localparam int unsigned NUM_ERR       = 5;

  // The capture record is sized for the widest supported bus; narrower buses are zero-extended.
  localparam int unsigned MaxSelW  = 32;
  localparam int unsigned MaxAddrW = 64;
  localparam int unsigned MaxDataW = 128;
  localparam int unsigned MaxStrbW = MaxDataW / 8;

  // Setup-phase fields that must hold steady through the access phase.
  typedef struct packed {
    logic [MaxSelW-1:0]  psel;
    logic [MaxAddrW-1:0] paddr;
    logic                pwrite;
    logic [MaxDataW-1:0] pwdata;
    logic [MaxStrbW-1:0] pstrb;
    logic [2:0]          pprot;
  } setup_t;

  // Increment that sticks at max_val; counters up to 32 bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/apb_chk_stats.sv
// Saturating statistics: completed transfers, violation cycles and longest wait run.
module apb_chk_stats
  import apb_chk_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 done_i,
  input  logic                 err_i,
  input  logic [CNT_WIDTH-1:0] wait_i,
  output logic [CNT_WIDTH-1:0] xfer_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] max_wait_o
);

  localparam logic [31:0] CntMax = 32'({CNT_WIDTH{1'b1}});

  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] max_wait_q, max_wait_d;

  // Next-state counters, all saturating at all-ones.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    max_wait_d = max_wait_q;
    if (done_i) begin
      xfer_cnt_d = CNT_WIDTH'(sat_inc(32'(xfer_cnt_q), CntMax));
      if (wait_i > max_wait_q) max_wait_d = wait_i;
    end
    if (err_i) err_cnt_d = CNT_WIDTH'(sat_inc(32'(err_cnt_q), CntMax));
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
      max_wait_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign max_wait_o = max_wait_q;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB4 monitor: phase checks, field stability, wait timeout, transfer record and stats.
// Supports NUM_SEL <= 32, APB_ADDR_WIDTH <= 64, APB_DATA_WIDTH <= 128, CNT_WIDTH <= 32.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned NUM_SEL        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                        PCLK,
  input  logic                        rst,
  input  logic [NUM_SEL-1:0]          PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic [APB_DATA_WIDTH-1:0]   PWDATA,
  input  logic [APB_DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]                  PPROT,
  input  logic [APB_DATA_WIDTH-1:0]   PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR,
  input  logic                        err_clr,
  output logic [NUM_ERR-1:0]          err_pulse,
  output logic [NUM_ERR-1:0]          err_sticky,
  output logic                        xfer_done,
  output logic                        xfer_write,
  output logic [APB_ADDR_WIDTH-1:0]   xfer_addr,
  output logic [APB_DATA_WIDTH-1:0]   xfer_data,
  output logic                        xfer_slverr,
  output logic [NUM_SEL-1:0]          xfer_sel,
  output logic [CNT_WIDTH-1:0]        xfer_cnt,
  output logic [CNT_WIDTH-1:0]        err_cnt,
  output logic [CNT_WIDTH-1:0]        max_wait
);

  localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [31:0]          WaitMax    = 32'({CNT_WIDTH{1'b1}});

  chk_state_e                state_q, state_d;
  setup_t                    cap_q, cap_d, cur;
  logic [CNT_WIDTH-1:0]      wait_q, wait_d, wait_cur;
  logic                      unst_q, unst_d;
  logic [NUM_ERR-1:0]        pulse_d, sticky_d;
  logic                      done_d, rec_write_d, rec_slverr_d;
  logic [APB_ADDR_WIDTH-1:0] rec_addr_d;
  logic [APB_DATA_WIDTH-1:0] rec_data_d;
  logic [NUM_SEL-1:0]        rec_sel_d;
  logic                      in_access, do_capture, changed, sel_any, multi_sel;

  // Live bus in capture layout so it compares field-for-field with the setup record.
  always_comb begin
    cur        = '0;
    cur.psel   = MaxSelW'(PSEL);
    cur.paddr  = MaxAddrW'(PADDR);
    cur.pwrite = PWRITE;
    cur.pwdata = MaxDataW'(PWDATA);
    cur.pstrb  = MaxStrbW'(PSTRB);
    cur.pprot  = PPROT;
  end

  assign sel_any   = |PSEL;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_sel = |(PSEL & (PSEL - NUM_SEL'(1)));
  // Write data only has to hold on writes.
  assign changed   = (cur.psel != cap_q.psel) || (cur.paddr != cap_q.paddr) ||
                     (cur.pwrite != cap_q.pwrite) || (cur.pstrb != cap_q.pstrb) ||
                     (cur.pprot != cap_q.pprot) ||
                     (cap_q.pwrite && (cur.pwdata != cap_q.pwdata));

  // Phase tracking, violation detection and transfer record next-state.
  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    wait_d       = wait_q;
    unst_d       = unst_q;
    pulse_d      = '0;
    done_d       = 1'b0;
    rec_write_d  = xfer_write;
    rec_addr_d   = xfer_addr;
    rec_data_d   = xfer_data;
    rec_slverr_d = xfer_slverr;
    rec_sel_d    = xfer_sel;
    in_access    = 1'b0;
    do_capture   = 1'b0;
    wait_cur     = '0;

    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          if (PENABLE) pulse_d[ERR_ILLEGAL] = 1'b1;
          else         do_capture = 1'b1;
        end
      end
      StSetup: begin
        if (!sel_any) begin
          pulse_d[ERR_ILLEGAL] = 1'b1;
          state_d              = StIdle;
        end else if (!PENABLE) begin
          pulse_d[ERR_ILLEGAL] = 1'b1;
          do_capture           = 1'b1;
        end else if (cur.psel == cap_q.psel) begin
          // First access-phase sample: may already complete with zero waits.
          in_access = 1'b1;
        end else begin
          pulse_d[ERR_ILLEGAL] = 1'b1;
          state_d              = StIdle;
        end
      end
      StAccess: begin
        if (!sel_any || !PENABLE) begin
          pulse_d[ERR_ILLEGAL] = 1'b1;
          state_d              = StIdle;
        end else begin
          in_access = 1'b1;
          wait_cur  = wait_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_capture) begin
      state_d = StSetup;
      cap_d   = cur;
      unst_d  = 1'b0;
      if (!PWRITE && |PSTRB) pulse_d[ERR_STRB_READ] = 1'b1;
    end

    if (in_access) begin
      state_d = StAccess;
      if (changed && !unst_q) begin
        pulse_d[ERR_UNSTABLE] = 1'b1;
        unst_d                = 1'b1;
      end
      if (PREADY) begin
        state_d      = StIdle;
        done_d       = 1'b1;
        rec_write_d  = cap_q.pwrite;
        rec_addr_d   = cap_q.paddr[APB_ADDR_WIDTH-1:0];
        rec_data_d   = cap_q.pwrite ? cap_q.pwdata[APB_DATA_WIDTH-1:0] : PRDATA;
        rec_slverr_d = PSLVERR;
        rec_sel_d    = cap_q.psel[NUM_SEL-1:0];
      end else begin
        wait_d = CNT_WIDTH'(sat_inc(32'(wait_cur), WaitMax));
        // The != guard keeps a saturated counter from re-firing.
        if ((TIMEOUT_CYCLES != 0) && (wait_d == TimeoutVal) && (wait_d != wait_cur)) begin
          pulse_d[ERR_TIMEOUT] = 1'b1;
        end
      end
    end

    if (multi_sel) pulse_d[ERR_MULTI_SEL] = 1'b1;

    // A new pulse beats a simultaneous clear for its own bit.
    sticky_d = (err_sticky & ~{NUM_ERR{err_clr}}) | pulse_d;
  end

  // State, capture and output registers.
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cap_q       <= '0;
      wait_q      <= '0;
      unst_q      <= 1'b0;
      err_pulse   <= '0;
      err_sticky  <= '0;
      xfer_done   <= 1'b0;
      xfer_write  <= 1'b0;
      xfer_addr   <= '0;
      xfer_data   <= '0;
      xfer_slverr <= 1'b0;
      xfer_sel    <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      wait_q      <= wait_d;
      unst_q      <= unst_d;
      err_pulse   <= pulse_d;
      err_sticky  <= sticky_d;
      xfer_done   <= done_d;
      xfer_write  <= rec_write_d;
      xfer_addr   <= rec_addr_d;
      xfer_data   <= rec_data_d;
      xfer_slverr <= rec_slverr_d;
      xfer_sel    <= rec_sel_d;
    end
  end

  apb_chk_stats #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stats (
    .clk_i      (PCLK),
    .rst_i      (rst),
    .done_i     (done_d),
    .err_i      (|pulse_d),
    .wait_i     (wait_cur),
    .xfer_cnt_o (xfer_cnt),
    .err_cnt_o  (err_cnt),
    .max_wait_o (max_wait)
  );

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Self-checking bench for apb_protocol_checker: transaction-level model plus directed scenarios.
module tb_apb_protocol_checker;

  localparam int CMAX = 15;  // all-ones for the 4-bit counters used here
  localparam int TO   = 4;

  logic        PCLK = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  PSEL = '0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0, err_clr = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [2:0]  PPROT = '0;
  logic [4:0]  err_pulse, err_sticky;
  logic        xfer_done, xfer_write, xfer_slverr;
  logic [31:0] xfer_addr, xfer_data;
  logic [3:0]  xfer_sel, xfer_cnt, err_cnt, max_wait;

  always #5 PCLK = ~PCLK;

  apb_protocol_checker #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .NUM_SEL       (4),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (4)
  ) dut (
    .PCLK       (PCLK),
    .rst        (rst),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PPROT      (PPROT),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .xfer_done  (xfer_done),
    .xfer_write (xfer_write),
    .xfer_addr  (xfer_addr),
    .xfer_data  (xfer_data),
    .xfer_slverr(xfer_slverr),
    .xfer_sel   (xfer_sel),
    .xfer_cnt   (xfer_cnt),
    .err_cnt    (err_cnt),
    .max_wait   (max_wait)
  );

  int  n_tests = 0, n_fail = 0;
  bit  chk_en = 1'b0;
  int  seen[5] = '{0, 0, 0, 0, 0};
  int  seen_done = 0;
  time to_time = 0, t_setup = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0]  e_pulse = '0, e_sticky = '0;
  logic        e_done = 1'b0, e_write = 1'b0, e_slverr = 1'b0;
  logic [31:0] e_addr = '0, e_data = '0;
  logic [3:0]  e_sel = '0;
  int          e_xfer_cnt = 0, e_err_cnt = 0, e_max_wait = 0;
  int          m_phase = 0;  // 0: no transfer, 1: setup seen, 2: in access
  int          m_waits = 0;
  bit          m_unst = 1'b0;
  logic [3:0]  c_sel = '0, c_strb = '0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_write = 1'b0;
  logic [2:0]  c_prot = '0;

  always @(posedge PCLK or posedge rst) begin
    if (rst) begin
      e_pulse = '0; e_sticky = '0; e_done = 0; e_write = 0; e_slverr = 0;
      e_addr = '0; e_data = '0; e_sel = '0;
      e_xfer_cnt = 0; e_err_cnt = 0; e_max_wait = 0;
      m_phase = 0; m_waits = 0; m_unst = 0;
    end else begin : step
      logic [4:0] p;
      bit take, acc, done;
      p = '0; take = 0; acc = 0; done = 0;
      if ($countones(PSEL) > 1) p[3] = 1;
      if (m_phase == 0) begin
        if (PSEL != 0) begin
          if (PENABLE) p[0] = 1;
          else take = 1;
        end
      end else if (m_phase == 1) begin
        if (PSEL == 0) begin p[0] = 1; m_phase = 0; end
        else if (!PENABLE) begin p[0] = 1; take = 1; end
        else if (PSEL == c_sel) begin m_waits = 0; acc = 1; end
        else begin p[0] = 1; m_phase = 0; end
      end else begin
        if (PSEL == 0 || !PENABLE) begin p[0] = 1; m_phase = 0; end
        else acc = 1;
      end
      if (take) begin
        c_sel = PSEL; c_addr = PADDR; c_write = PWRITE; c_wdata = PWDATA;
        c_strb = PSTRB; c_prot = PPROT; m_unst = 0; m_phase = 1;
        if (!PWRITE && PSTRB != 0) p[4] = 1;
      end
      if (acc) begin
        m_phase = 2;
        if (!m_unst && (PSEL != c_sel || PADDR != c_addr || PWRITE != c_write ||
                        PSTRB != c_strb || PPROT != c_prot || (c_write && PWDATA != c_wdata))) begin
          p[1] = 1; m_unst = 1;
        end
        if (PREADY) begin
          done = 1; m_phase = 0;
          e_write = c_write; e_addr = c_addr; e_sel = c_sel; e_slverr = PSLVERR;
          e_data = c_write ? c_wdata : PRDATA;
          if (e_xfer_cnt < CMAX) e_xfer_cnt++;
          if (m_waits > e_max_wait) e_max_wait = m_waits;
        end else if (m_waits < CMAX) begin
          m_waits++;
          if (m_waits == TO) p[2] = 1;
        end
      end
      e_pulse  = p;
      e_done   = done;
      e_sticky = (err_clr ? 5'b0 : e_sticky) | p;
      if (p != 0 && e_err_cnt < CMAX) e_err_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge PCLK) begin
    if (chk_en) begin
      check("err_pulse", err_pulse, e_pulse);
      check("err_sticky", err_sticky, e_sticky);
      check("xfer_done", xfer_done, e_done);
      check("xfer_write", xfer_write, e_write);
      check("xfer_addr", xfer_addr, e_addr);
      check("xfer_data", xfer_data, e_data);
      check("xfer_slverr", xfer_slverr, e_slverr);
      check("xfer_sel", xfer_sel, e_sel);
      check("xfer_cnt", xfer_cnt, e_xfer_cnt);
      check("err_cnt", err_cnt, e_err_cnt);
      check("max_wait", max_wait, e_max_wait);
      if (xfer_done) seen_done++;
      for (int i = 0; i < 5; i++) begin
        if (err_pulse[i]) begin
          seen[i]++;
          if (i == 2) to_time = $time;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PCLK);
      PSEL = '0; PENABLE = 0; PREADY = 0; PSLVERR = 0; err_clr = 0;
    end
  endtask

  // One transfer: a setup sample, then waits+1 access samples. chg>=0 flips PADDR from that
  // access sample onward; clr raises err_clr on the setup sample.
  task automatic xfer(input logic [3:0] sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input int waits,
                      input bit slverr, input int chg, input bit clr);
    @(negedge PCLK);
    t_setup = $time;
    PSEL = sel; PENABLE = 0; PWRITE = wr; PADDR = addr; PSTRB = strb; PPROT = 3'b010;
    PWDATA = wr ? data : $urandom; PRDATA = $urandom; PREADY = 0; PSLVERR = 0; err_clr = clr;
    for (int k = 0; k <= waits; k++) begin
      @(negedge PCLK);
      err_clr = 0; PENABLE = 1;
      if (k == chg) PADDR = addr ^ 32'h4;
      PREADY  = (k == waits);
      PSLVERR = (k == waits) && slverr;
      PRDATA  = (!wr && k == waits) ? data : $urandom;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench time limit expired");
  end

  initial begin : main
    int s0, s1, s2, s3, sd;
    // Reset state
    @(negedge PCLK); #2;
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_xfer_done", xfer_done, 0);
    check("rst_max_wait", max_wait, 0);
    check("rst_err_pulse", err_pulse, 0);
    @(negedge PCLK); rst = 0; chk_en = 1;
    idle(2);

    // Write with 2 waits, then back-to-back read with 0 waits
    xfer(4'b0001, 1, 32'h40, 32'hA5A5_0001, 4'hF, 2, 0, -1, 0);
    xfer(4'b0001, 0, 32'h44, 32'h1234_5678, 4'h0, 0, 0, -1, 0);
    idle(1); #2;
    check("t1_done", xfer_done, 1);
    check("t1_xfer_cnt", xfer_cnt, 2);
    check("t1_max_wait", max_wait, 2);
    check("t1_sticky", err_sticky, 0);
    check("t1_write", xfer_write, 0);
    check("t1_data", xfer_data, 32'h1234_5678);
    check("t1_addr", xfer_addr, 32'h44);
    check("t1_err_cnt", err_cnt, 0);

    // PADDR changes in the second access sample of a 3-wait write
    s1 = seen[1]; sd = seen_done;
    xfer(4'b0010, 1, 32'h80, 32'hDEAD_0002, 4'hF, 3, 0, 1, 0);
    idle(1); #2;
    check("t2_unstable_count", seen[1] - s1, 1);
    check("t2_done_count", seen_done - sd, 1);
    check("t2_sel", xfer_sel, 4'b0010);
    check("t2_max_wait", max_wait, 3);
    check("t2_sticky", err_sticky, 5'b00010);
    check("t2_err_cnt", err_cnt, 1);

    // PREADY low for 10 samples with TIMEOUT_CYCLES=4
    s2 = seen[2];
    xfer(4'b0100, 1, 32'hC0, 32'h0000_0003, 4'hF, 10, 0, -1, 0);
    idle(1); #2;
    check("t3_timeout_count", seen[2] - s2, 1);
    check("t3_timeout_cycle", to_time - t_setup, 50);
    check("t3_max_wait", max_wait, 10);
    check("t3_xfer_cnt", xfer_cnt, 4);

    // Two selects in an idle sample, then PENABLE with a different select
    @(negedge PCLK); err_clr = 1;
    s0 = seen[0]; s3 = seen[3];
    @(negedge PCLK);
    err_clr = 0; PSEL = 4'b0101; PENABLE = 0; PWRITE = 1; PSTRB = 4'hF;
    @(negedge PCLK);
    PSEL = 4'b0001; PENABLE = 1;
    idle(1); #2;
    check("t4_illegal_count", seen[0] - s0, 1);
    check("t4_multi_count", seen[3] - s3, 1);
    check("t4_pulse", err_pulse, 5'b00001);
    check("t4_sticky", err_sticky, 5'b01001);
    check("t4_err_cnt", err_cnt, 4);

    // Read with strobes set, err_clr on the same sample as the violation
    xfer(4'b0001, 0, 32'h100, 32'h55AA_55AA, 4'hF, 0, 1, -1, 1);
    idle(1); #2;
    check("t5_sticky", err_sticky, 5'b10000);
    check("t5_slverr", xfer_slverr, 1);
    check("t5_data", xfer_data, 32'h55AA_55AA);
    check("t5_err_cnt", err_cnt, 5);

    // Asynchronous reset during access
    @(negedge PCLK);
    PSEL = 4'b0001; PENABLE = 0; PWRITE = 1; PADDR = 32'h200; PSTRB = 4'hF; PREADY = 0;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK);
    #2 rst = 1;
    #1;
    check("t6_rst_xfer_cnt", xfer_cnt, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_sticky", err_sticky, 0);
    check("t6_rst_addr", xfer_addr, 0);
    check("t6_rst_data", xfer_data, 0);
    check("t6_rst_sel", xfer_sel, 0);
    check("t6_rst_max_wait", max_wait, 0);
    idle(1);
    #2 rst = 0;
    xfer(4'b0001, 1, 32'h204, 32'h0000_0077, 4'hF, 1, 0, -1, 0);
    idle(1); #2;
    check("t6_xfer_cnt", xfer_cnt, 1);
    check("t6_sticky", err_sticky, 0);
    check("t6_max_wait", max_wait, 1);

    // Saturation: long wait, many transfers, many violation cycles
    s2 = seen[2];
    xfer(4'b1000, 1, 32'h300, 32'h0000_0300, 4'hF, 20, 0, -1, 0);
    idle(1); #2;
    check("t7_max_wait_sat", max_wait, 15);
    check("t7_timeout_count", seen[2] - s2, 1);
    for (int i = 0; i < 16; i++) xfer(4'b0001, 1, 32'h400 + 32'(i * 4), 32'(i), 4'hF, 0, 0, -1, 0);
    idle(1); #2;
    check("t7_xfer_cnt_sat", xfer_cnt, 15);
    repeat (16) begin
      @(negedge PCLK); PSEL = 4'b0001; PENABLE = 1;
    end
    idle(1); #2;
    check("t7_err_cnt_sat", err_cnt, 15);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
